lpf_cfg_ctrl: RTL and testbench

LPF_CFG_CTRL -- requirements
Module: lpf_cfg_ctrl

---
 rtl/lpf_cfg_pkg.sv | 20 ++
 rtl/lpf_thr_bank.sv | 43 ++++
 rtl/lpf_cfg_ctrl.sv | 112 +++++++++++
 tb/tb_lpf_cfg_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lpf_cfg_pkg.sv
// lpf_cfg_pkg: shared opcode/state encodings, threshold width and status field positions
package lpf_cfg_pkg;
  localparam int TW = 14;
  typedef enum logic [1:0] {
    OP_SELECT  = 2'b00,
    OP_WRITE   = 2'b01,
    OP_COMMIT  = 2'b10,
    OP_CONTROL = 2'b11
  } opcode_e;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_APPLY    = 2'd2
  } state_e;
  localparam int ST_ERR_BIT   = 15;
  localparam int ST_BUSY_BIT  = 14;
  localparam int ST_STATE_LSB = 12;
  localparam int ST_SEL_LSB   = 10;
  localparam int ST_PEND_LSB  = 6;
endpackage

// File: rtl/lpf_thr_bank.sv
// lpf_thr_bank: per-channel shadow/active threshold registers with pending-write tracking
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_wr_en/ch/data  shadow write of one channel (marks it pending)
//   i_commit_mask    copy shadow to active for each set bit (clears pending)
//   i_clr_pend       drop all pending marks
//   o_thr            active thresholds, channel i at [i*TW +: TW]
//   o_pend           pending-write mask
module lpf_thr_bank #(
  parameter int NCH = 4,
  parameter int TW = 14,
  parameter logic [TW-1:0] DEF_THR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [1:0]        i_wr_ch,
  input  logic [TW-1:0]     i_wr_data,
  input  logic [NCH-1:0]    i_commit_mask,
  input  logic              i_clr_pend,
  output logic [NCH*TW-1:0] o_thr,
  output logic [NCH-1:0]    o_pend
);
  logic [TW-1:0] r_shadow [NCH];
  logic [TW-1:0] r_thr [NCH];
  logic          r_pend [NCH];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic w_hit;
    assign w_hit = i_wr_en && i_wr_ch == 2'(i);
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_shadow[i] <= DEF_THR;
        r_thr[i]    <= DEF_THR;
        r_pend[i]   <= 1'b0;
      end else begin
        if (w_hit) r_shadow[i] <= i_wr_data;
        if (i_commit_mask[i]) r_thr[i] <= r_shadow[i];
        r_pend[i] <= w_hit ? 1'b1 : (i_clr_pend || i_commit_mask[i]) ? 1'b0 : r_pend[i];
      end
    assign o_thr[i*TW +: TW] = r_thr[i];
    assign o_pend[i] = r_pend[i];
  end
endmodule

// File: rtl/lpf_cfg_ctrl.sv
// lpf_cfg_ctrl: SPI-word driven configuration of per-channel low-pass-filter thresholds
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   i_rx_data    {opcode[1:0], payload[13:0]}
//   o_thr        active threshold per channel, channel i at [i*TW +: TW]
//   o_lpf_rst    one-cycle per-channel filter reset, high during the APPLY cycle
//   o_status     {err, busy, state, sel_ch, pend_mask, 6'b0}
//   o_err        sticky protocol error
module lpf_cfg_ctrl #(
  parameter int NCH = 4,
  parameter int TW = lpf_cfg_pkg::TW,
  parameter int TIMEOUT = 1024,
  parameter logic [TW-1:0] DEF_THR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx_valid,
  input  logic [15:0]       i_rx_data,
  output logic [NCH*TW-1:0] o_thr,
  output logic [NCH-1:0]    o_lpf_rst,
  output logic [15:0]       o_status,
  output logic              o_err
);
  import lpf_cfg_pkg::*;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0] VALID_MASK = 4'((1 << NCH) - 1);
  state_e         r_state, w_state_nx, r_ret_state;
  logic [1:0]     r_sel_ch;
  logic [CW-1:0]  r_cnt;
  logic           r_err;
  logic [NCH-1:0] r_eff_mask, r_lpf_rst, w_pend, w_commit_mask;
  logic [3:0]     w_pend4, w_eff;
  opcode_e        w_op;
  logic [13:0]    w_pl;
  logic           w_cmd, w_sel_ok, w_expire;
  logic           w_sel, w_wr, w_commit, w_clr_err, w_abort, w_set_err;
  assign w_op = opcode_e'(i_rx_data[15:14]);
  assign w_pl = i_rx_data[13:0];
  // Words arriving while APPLY is in progress are never acted upon.
  assign w_cmd = i_rx_valid && r_state != ST_APPLY;
  // The whole payload is compared so out-of-range values like 5 are rejected rather than aliased.
  assign w_sel_ok = int'(w_pl) < NCH;
  // A word in the expiry cycle wins over the timeout.
  assign w_expire = r_state == ST_SELECTED && !i_rx_valid && r_cnt == CW'(TIMEOUT - 1);
  assign w_pend4 = 4'(w_pend);
  assign w_eff = w_pl[3:0] & w_pend4 & VALID_MASK;
  assign w_commit_mask = r_state == ST_APPLY ? r_eff_mask : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  always_comb begin
    w_state_nx = r_state == ST_APPLY ? r_ret_state :
                 (w_expire || w_wr || w_abort) ? ST_IDLE :
                 w_commit ? ST_APPLY :
                 w_sel ? ST_SELECTED : r_state;
  end
  always_comb begin
    w_sel     = w_cmd && w_op == OP_SELECT && w_sel_ok;
    w_wr      = w_cmd && w_op == OP_WRITE && r_state == ST_SELECTED;
    w_commit  = w_cmd && w_op == OP_COMMIT;
    w_clr_err = w_cmd && w_op == OP_CONTROL && w_pl[0];
    w_abort   = w_cmd && w_op == OP_CONTROL && w_pl[1];
    w_set_err = w_expire || (i_rx_valid && r_state == ST_APPLY) ||
                (w_cmd && w_op == OP_SELECT && !w_sel_ok) ||
                (w_cmd && w_op == OP_WRITE && r_state == ST_IDLE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_err       <= 1'b0;
      r_sel_ch    <= 2'd0;
      r_cnt       <= '0;
      r_ret_state <= ST_IDLE;
      r_eff_mask  <= '0;
      r_lpf_rst   <= '0;
    end else begin
      r_err <= w_set_err ? 1'b1 : w_clr_err ? 1'b0 : r_err;
      if (w_sel) r_sel_ch <= w_pl[1:0];
      r_cnt <= w_sel ? '0 :
               (r_state == ST_SELECTED && !i_rx_valid && !w_expire) ? r_cnt + CW'(1) : r_cnt;
      if (w_commit) begin
        r_ret_state <= r_state;
        r_eff_mask  <= w_eff[NCH-1:0];
      end
      r_lpf_rst <= (w_commit && w_pl[4]) ? w_eff[NCH-1:0] : '0;
    end
  lpf_thr_bank #(
    .NCH    (NCH),
    .TW     (TW),
    .DEF_THR(DEF_THR)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (w_wr),
    .i_wr_ch      (r_sel_ch),
    .i_wr_data    (w_pl[TW-1:0]),
    .i_commit_mask(w_commit_mask),
    .i_clr_pend   (w_abort),
    .o_thr        (o_thr),
    .o_pend       (w_pend)
  );
  always_comb begin
    o_status = '0;
    o_status[ST_ERR_BIT] = r_err;
    o_status[ST_BUSY_BIT] = r_state != ST_IDLE;
    o_status[ST_STATE_LSB +: 2] = r_state;
    o_status[ST_SEL_LSB +: 2] = r_sel_ch;
    o_status[ST_PEND_LSB +: 4] = w_pend4;
  end
  assign o_err = r_err;
  assign o_lpf_rst = r_lpf_rst;
endmodule

// File: tb/tb_lpf_cfg_ctrl.sv
// tb_lpf_cfg_ctrl: directed and randomized checks of lpf_cfg_ctrl against a behavioural model
module tb_lpf_cfg_ctrl;
  localparam int NCH = 4;
  localparam int TW = 14;
  localparam int TIMEOUT = 1024;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic [NCH*TW-1:0] thr;
  logic [NCH-1:0] lpf_rst;
  logic [15:0] status;
  logic err;
  int n_chk = 0;
  int n_bad = 0;
  int m_thr [NCH];
  int m_shd [NCH];
  bit m_pend [NCH];
  bit m_err;
  int m_mode;
  int m_sel;
  int m_idle;
  int m_ret;
  bit [3:0] m_amask;
  bit [3:0] m_lpf;
  lpf_cfg_ctrl #(
    .NCH(NCH), .TW(TW), .TIMEOUT(TIMEOUT), .DEF_THR(14'h0)
  ) dut (
    .clk(clk), .reset(reset), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_thr(thr), .o_lpf_rst(lpf_rst), .o_status(status), .o_err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] pend_bits();
    logic [3:0] p = '0;
    for (int i = 0; i < NCH; i++) p[i] = m_pend[i];
    return p;
  endfunction
  function automatic logic [15:0] cmd(input logic [1:0] op, input logic [13:0] pl);
    return {op, pl};
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_thr[i] = 0;
      m_shd[i] = 0;
      m_pend[i] = 0;
    end
    m_err = 0; m_mode = 0; m_sel = 0; m_idle = 0; m_ret = 0; m_amask = 0; m_lpf = 0;
  endfunction
  // mode: 0 idle, 1 channel selected, 2 applying a commit
  function automatic void model_step(input bit v, input logic [15:0] w);
    logic [1:0] op = w[15:14];
    logic [13:0] pl = w[13:0];
    m_lpf = 0;
    if (m_mode == 2) begin
      for (int i = 0; i < NCH; i++)
        if (m_amask[i]) begin
          m_thr[i] = m_shd[i];
          m_pend[i] = 0;
        end
      m_mode = m_ret;
      if (v) m_err = 1;
    end else if (v) begin
      if (op == 2'd0) begin
        if (pl < NCH) begin
          m_mode = 1; m_sel = int'(pl); m_idle = 0;
        end else m_err = 1;
      end else if (op == 2'd1) begin
        if (m_mode == 1) begin
          m_shd[m_sel] = int'(pl[TW-1:0]); m_pend[m_sel] = 1; m_mode = 0;
        end else m_err = 1;
      end else if (op == 2'd2) begin
        m_amask = pl[3:0] & pend_bits();
        m_ret = m_mode;
        m_mode = 2;
        if (pl[4]) m_lpf = m_amask;
      end else begin
        if (pl[0]) m_err = 0;
        if (pl[1]) begin
          m_mode = 0;
          for (int i = 0; i < NCH; i++) m_pend[i] = 0;
        end
      end
    end else if (m_mode == 1) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_err = 1; m_mode = 0;
      end
    end
  endfunction
  task automatic check_all();
    logic [15:0] st;
    for (int i = 0; i < NCH; i++) check($sformatf("thr%0d", i), thr[i*TW +: TW], m_thr[i]);
    check("lpf_rst", lpf_rst, m_lpf);
    check("err", err, m_err);
    st = {m_err, m_mode != 0, 2'(m_mode), 2'(m_sel), pend_bits(), 6'b0};
    check("status", status, st);
  endtask
  task automatic step(input bit v, input logic [15:0] w);
    rx_valid = v;
    rx_data = w;
    @(posedge clk);
    model_step(v, w);
    @(negedge clk);
    rx_valid = 1'b0;
    check_all();
  endtask
  initial begin
    logic [1:0] op;
    logic [13:0] pl;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    step(0, 0);
    // basic select / write / commit with filter reset pulse
    step(1, cmd(0, 2));
    step(1, cmd(1, 14'h100));
    step(1, cmd(2, 14'h14));
    check("r034_lpf", lpf_rst, 4'b0100);
    check("r034_thr2_pre", thr[2*TW +: TW], 0);
    step(0, 0);
    check("r034_thr2", thr[2*TW +: TW], 14'h100);
    check("r034_thr0", thr[0 +: TW], 0);
    check("r034_lpf_end", lpf_rst, 0);
    // selection timeout
    step(1, cmd(0, 1));
    repeat (TIMEOUT) step(0, 0);
    check("r035_err", err, 1);
    check("r035_state", status[13:12], 0);
    step(1, cmd(1, 14'h55));
    step(1, cmd(2, 14'h0F));
    step(0, 0);
    check("r035_thr1", thr[1*TW +: TW], 0);
    step(1, cmd(3, 1));
    check("r035_clr", err, 0);
    // protocol errors
    step(1, cmd(1, 14'h123));
    check("r036_wr_idle", err, 1);
    step(1, cmd(3, 1));
    step(1, cmd(0, 5));
    check("r036_sel5", err, 1);
    check("r036_state", status[13:12], 0);
    step(1, cmd(3, 1));
    // partial commits
    step(1, cmd(0, 0));
    step(1, cmd(1, 14'h0AA));
    step(1, cmd(0, 3));
    step(1, cmd(1, 14'h333));
    step(1, cmd(2, 14'h01));
    step(0, 0);
    check("r037_thr0", thr[0 +: TW], 14'h0AA);
    check("r037_thr3", thr[3*TW +: TW], 0);
    step(1, cmd(2, 14'h0F));
    step(0, 0);
    check("r037_thr3b", thr[3*TW +: TW], 14'h333);
    check("r037_pend", status[9:6], 0);
    // empty commit, then a word landing on the APPLY cycle
    step(1, cmd(2, 14'h1F));
    check("r025_lpf", lpf_rst, 0);
    check("r025_err", err, 0);
    step(1, cmd(0, 1));
    check("r038_drop_err", err, 1);
    check("r038_drop_sel", status[11:10], 3);
    step(1, cmd(3, 1));
    // word on the timeout-expiry cycle is processed
    step(1, cmd(0, 2));
    repeat (TIMEOUT - 1) step(0, 0);
    step(1, cmd(1, 14'h2AA));
    check("r038_exp_err", err, 0);
    check("r038_exp_pend", status[8], 1);
    // asynchronous reset in the middle of a sequence
    step(1, cmd(0, 1));
    step(1, cmd(1, 14'h111));
    step(1, cmd(0, 0));
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check("r039_lpf", lpf_rst, 0);
    @(negedge clk);
    reset = 1'b0;
    check_all();
    step(1, cmd(2, 14'h1F));
    step(0, 0);
    // randomized traffic
    repeat (400) begin
      op = 2'($urandom_range(0, 3));
      pl = op == 2'd0 ? 14'($urandom_range(0, 5)) :
           op == 2'd1 ? 14'($urandom) :
           op == 2'd2 ? 14'($urandom_range(0, 31)) : 14'($urandom_range(0, 3));
      step(1, cmd(op, pl));
      repeat ($urandom_range(0, 3)) step(0, 0);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
